// File: rtl/dsm_dac_gen2.sv
// dsm_dac_gen2: 1-bit delta-sigma DAC (1st/2nd order) with a one-entry input
// buffer, OSR-paced sample loading, saturating integrators and status pulses.
`default_nettype none

module dsm_dac_gen2 #(
    parameter int DATA_WIDTH   = 4,
    parameter int ACC_WIDTH    = DATA_WIDTH + 4,
    parameter int ORDER        = 2,
    parameter int FEEDBACK_MAG = 2 ** (DATA_WIDTH - 1),
    parameter int OSR          = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sample,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_dac_out,
    output logic                  o_underrun,
    output logic                  o_sat
);

    localparam int C_AW = (ACC_WIDTH > DATA_WIDTH + 3) ? ACC_WIDTH : DATA_WIDTH + 3;
    localparam int C_SW = C_AW + 2;
    localparam int C_CW = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [C_CW-1:0]        C_LAST = C_CW'(OSR - 1);
    localparam logic signed [C_SW-1:0] C_FB   = C_SW'(FEEDBACK_MAG);
    localparam logic signed [C_SW-1:0] C_MAX  = (C_SW'(1) <<< (C_AW - 1)) - C_SW'(1);
    localparam logic signed [C_SW-1:0] C_MIN  = -C_MAX - C_SW'(1);

    generate
        if (ORDER != 1 && ORDER != 2) begin : g_order_check
            $error("dsm_dac_gen2: ORDER must be 1 or 2");
        end
    endgenerate

    logic                         r_buf_full;
    logic        [DATA_WIDTH-1:0] r_buf;
    logic        [DATA_WIDTH-1:0] r_x;
    logic        [C_CW-1:0]       r_osr_cnt;
    logic signed [C_AW-1:0]       r_int1;
    logic                         r_dac;
    logic                         r_underrun;
    logic                         r_sat;

    logic                         w_bnd;
    logic                         w_xfer;
    logic signed [C_SW-1:0]       w_fb;
    logic signed [C_SW-1:0]       w_sum1;
    logic                         w_clamp1;
    logic signed [C_AW-1:0]       w_int1_nxt;
    logic signed [C_AW-1:0]       w_last_nxt;
    logic                         w_clamp2;

    assign o_ready    = ~r_buf_full;
    assign o_dac_out  = r_dac;
    assign o_underrun = r_underrun;
    assign o_sat      = r_sat;

    assign w_bnd  = i_sample && (r_osr_cnt == C_LAST);
    assign w_xfer = i_valid && ~r_buf_full;
    assign w_fb   = r_dac ? C_FB : -C_FB;

    assign w_sum1 = {{2{r_int1[C_AW-1]}}, r_int1}
                  + {{(C_SW-DATA_WIDTH){r_x[DATA_WIDTH-1]}}, r_x}
                  - w_fb;
    assign w_clamp1   = (w_sum1 > C_MAX) || (w_sum1 < C_MIN);
    assign w_int1_nxt = (w_sum1 > C_MAX) ? C_MAX[C_AW-1:0] :
                        (w_sum1 < C_MIN) ? C_MIN[C_AW-1:0] : w_sum1[C_AW-1:0];

    generate
        if (ORDER == 2) begin : g_order2
            logic signed [C_AW-1:0] r_int2;
            logic signed [C_SW-1:0] w_sum2;

            assign w_sum2 = {{2{r_int2[C_AW-1]}}, r_int2}
                          + {{2{w_int1_nxt[C_AW-1]}}, w_int1_nxt}
                          - w_fb;
            assign w_clamp2   = (w_sum2 > C_MAX) || (w_sum2 < C_MIN);
            assign w_last_nxt = (w_sum2 > C_MAX) ? C_MAX[C_AW-1:0] :
                                (w_sum2 < C_MIN) ? C_MIN[C_AW-1:0] : w_sum2[C_AW-1:0];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_int2 <= '0;
                end else if (i_sample) begin
                    r_int2 <= w_last_nxt;
                end
            end
        end else begin : g_order1
            assign w_clamp2   = 1'b0;
            assign w_last_nxt = w_int1_nxt;
        end
    endgenerate

    // Boundary with a full buffer drains it (o_ready is low, so no refill
    // can collide); otherwise a handshake fills the buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_full <= 1'b0;
            r_buf      <= '0;
            r_x        <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_bnd && ~r_buf_full;
            if (w_bnd && r_buf_full) begin
                r_x        <= r_buf;
                r_buf_full <= 1'b0;
            end else if (w_xfer) begin
                r_buf      <= i_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_osr_cnt <= '0;
            r_int1    <= '0;
            r_dac     <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_sat <= i_sample && (w_clamp1 || w_clamp2);
            if (i_sample) begin
                r_osr_cnt <= w_bnd ? '0 : r_osr_cnt + C_CW'(1);
                r_int1    <= w_int1_nxt;
                r_dac     <= ~w_last_nxt[C_AW-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dsm_dac_gen2.sv
// tb_dsm_dac_gen2: directed + randomized checks of dsm_dac_gen2 against an
// integer-arithmetic reference model of the modulator and its input buffer.
`default_nettype none

module tb_dsm_dac_gen2;

    localparam int DW  = 4;
    localparam int AW  = DW + 3;
    localparam int ORD = 2;
    localparam int FB  = 8;
    localparam int OSR = 4;
    localparam int HI  = (1 << (AW - 1)) - 1;
    localparam int LO  = -(1 << (AW - 1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s, v;
    logic [DW-1:0] d;
    logic          ready, dac, und, sat;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_int1, m_int2, m_x, m_cnt;
    bit m_dac, m_und, m_sat;
    int m_q[$];
    int ones;

    always #5 clk = ~clk;

    dsm_dac_gen2 #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .ORDER       (ORD),
        .FEEDBACK_MAG(FB),
        .OSR         (OSR)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_sample  (s),
        .i_valid   (v),
        .o_ready   (ready),
        .i_data    (d),
        .o_dac_out (dac),
        .o_underrun(und),
        .o_sat     (sat)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input int val, inout bit hit);
        if (val > HI) begin hit = 1'b1; return HI; end
        if (val < LO) begin hit = 1'b1; return LO; end
        return val;
    endfunction

    task automatic model_reset();
        m_int1 = 0; m_int2 = 0; m_x = 0; m_cnt = 0;
        m_dac = 1'b0; m_und = 1'b0; m_sat = 1'b0;
        m_q.delete();
    endtask

    // One clock of the modulator as described in words: integrate x minus
    // the feedback reference, quantise by sign, pace samples every OSR steps.
    task automatic model_clock(input bit smp, input bit vld, input int din);
        bit full, bnd, hit;
        int fbv, a, b;
        full = (m_q.size() != 0);
        bnd  = smp && (m_cnt == OSR - 1);
        hit  = 1'b0;
        if (smp) begin
            fbv    = m_dac ? FB : -FB;
            a      = clampv(m_int1 + m_x - fbv, hit);
            b      = clampv(m_int2 + a - fbv, hit);
            m_int1 = a;
            m_int2 = b;
            m_dac  = (b >= 0);
            m_cnt  = (m_cnt + 1) % OSR;
        end
        m_sat = smp && hit;
        m_und = bnd && !full;
        if (bnd && full) m_x = m_q.pop_front();
        else if (vld && !full) m_q.push_back(din);
    endtask

    task automatic step(input bit smp, input bit vld, input logic [DW-1:0] din);
        s = smp; v = vld; d = din;
        @(posedge clk);
        model_clock(smp, vld, int'($signed(din)));
        #1;
        chk("dac_out",  dac,   m_dac);
        chk("ready",    ready, m_q.size() == 0);
        chk("underrun", und,   m_und);
        chk("sat",      sat,   m_sat);
        if (dac) ones++;
    endtask

    initial begin
        rst_n = 1'b0; s = 1'b0; v = 1'b0; d = '0;
        ones = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dac", dac, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_underrun", und, 1'b0);
        chk("rst_sat", sat, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // One sample then starve the input: underrun every OSR-th step
        step(1'b1, 1'b1, 4'd5);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 4'd0);

        // Input always offered: boundaries drain a full buffer, refill next cycle
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'($urandom));

        // Idle steps hold state while the handshake stays live
        for (int i = 0; i < 6; i++) step(1'b0, (i == 0), 4'd3);

        // Randomised traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, DW'($urandom));

        // Asynchronous reset mid-stream, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dac", dac, 1'b0);
        chk("async_rst_ready", ready, 1'b1);
        chk("async_rst_underrun", und, 1'b0);
        chk("async_rst_sat", sat, 1'b0);
        model_reset();
        s = 1'b0; v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First boundary after reset lands on the OSR-th step (underrun there)
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'd0);

        // Negative full-scale sustained drives the integrators into the clamp
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 4'b1000);

        // Positive near-full-scale: mostly ones
        ones = 0;
        for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 4'd7);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, DW'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dsm_dac_gen2.md
DSM_DAC_GEN2 -- requirements
Module: dsm_dac_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, signed input sample width (>=2).
REQ-002 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+4, integrator width; effective width SHALL be max(ACC_WIDTH, DATA_WIDTH+3).
REQ-003 SHALL have parameter ORDER, default 2, loop order; legal values 1 or 2, others SHALL fail elaboration.
REQ-004 SHALL have parameter FEEDBACK_MAG, default 2**(DATA_WIDTH-1), feedback magnitude (full-scale reference).
REQ-005 SHALL have parameter OSR, default 16, modulator steps per input sample (>=2).
REQ-006 SHALL have port i_clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_sample, input, 1, modulator step enable.
REQ-009 SHALL have port i_valid, input, 1, input sample valid.
REQ-010 SHALL have port o_ready, output, 1, input buffer can accept.
REQ-011 SHALL have port i_data, input, DATA_WIDTH signed, input sample.
REQ-012 SHALL have port o_dac_out, output, 1, registered 1-bit modulator output.
REQ-013 SHALL have port o_underrun, output, 1, one-cycle pulse when an input is missing at an OSR boundary.
REQ-014 SHALL have port o_sat, output, 1, one-cycle pulse when any integrator clamps.

Function
REQ-015 Input handshake: transfer occurs when i_valid && o_ready; data SHALL be captured into a one-entry buffer; o_ready SHALL equal ~buffer_full (registered, no same-cycle pass-through).
REQ-016 Step counter osr_cnt SHALL increment on each i_sample cycle and wrap from OSR-1 to 0; no change when i_sample=0.
REQ-017 At boundary (i_sample && osr_cnt==OSR-1): if buffer full, active sample x SHALL load from buffer and buffer SHALL empty; else x SHALL hold and o_underrun SHALL pulse.
REQ-018 Boundary with empty buffer and simultaneous handshake: data SHALL enter buffer, x SHALL hold, o_underrun SHALL pulse.
REQ-019 Boundary with full buffer: o_ready is 0 that cycle; buffer refills no earlier than next cycle.
REQ-020 Feedback fb SHALL be +FEEDBACK_MAG when o_dac_out=1, -FEEDBACK_MAG when 0, using the current registered o_dac_out.
REQ-021 On i_sample: int1_next = sat(int1 + x - fb); ORDER=2 also int2_next = sat(int2 + int1_next - fb).
REQ-022 x used in a step SHALL be the active value before any boundary load in that same cycle.
REQ-023 sat() SHALL clamp to [-2**(W-1), 2**(W-1)-1] (W = effective width), with all sums computed at W+2 bits sign-extended; o_sat SHALL pulse the cycle after any clamp.
REQ-024 o_dac_out SHALL update on i_sample to (last-stage integrator next value >= 0); latency one clock from i_sample.
REQ-025 With i_sample=0 integrators, o_dac_out, osr_cnt and x SHALL hold; handshake remains active.

Reset
REQ-026 While i_rst_n=0: o_dac_out=0, o_ready=1, o_underrun=0, o_sat=0, integrators=0, x=0, osr_cnt=0, buffer empty.
REQ-027 Reset asserted mid-operation SHALL discard buffered and active data immediately (asynchronous).
REQ-028 First boundary after reset SHALL occur on the OSR-th i_sample.

Verification
REQ-029 Reset: assert i_rst_n=0 mid-stream -> all outputs at REQ-026 values within same cycle, buffer empty.
REQ-030 ORDER=1, DATA_WIDTH=4, x=0, i_sample=1 continuous -> o_dac_out sequence 1,1,0,1,0,...; ones in 64 steps = 32 +/-1.
REQ-031 ORDER=2, x=+7, FEEDBACK_MAG=8 -> ones in 256 steps = 240 +/-2; x=-8 -> ones = 0 +/-2 with o_sat pulses allowed.
REQ-032 OSR=4, i_valid held 0 after one sample -> o_underrun pulses at every 4th i_sample, x unchanged.
REQ-033 Buffer full, i_valid=1 at boundary -> o_ready=0 that cycle, 1 next cycle, no data lost or duplicated.
REQ-034 ACC_WIDTH forced to minimum, ORDER=2, x=-8 sustained -> o_sat pulses, integrators pinned at -2**(W-1), no wrap to positive.
